// File: rtl/usb_pkg.sv
// Shared constants and types for the USB full-speed transmit path.
package usb_pkg;
  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam logic [1:0] LINE_J      = 2'b10;
  localparam logic [1:0] LINE_K      = 2'b01;
  localparam logic [1:0] LINE_SE0    = 2'b00;
  localparam int         STUFF_LIMIT = 6;

  typedef enum bit [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J, DONE} tx_state_t;

  // NRZI: a 0 toggles J/K, a 1 holds the line.
  function automatic logic [1:0] nrzi(input logic [1:0] line, input logic b);
    return b ? line : ((line == LINE_J) ? LINE_K : LINE_J);
  endfunction
endpackage

// File: rtl/usb_tx_if.sv
// FIFO-side handshake and status signals of the USB transmitter.
interface usb_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_empty;
  logic       tx_read;
  logic       tx_busy;
  logic       tx_done;

  modport master (output tx_start, tx_data, tx_empty, input tx_read, tx_busy, tx_done);
  modport slave  (input tx_start, tx_data, tx_empty, output tx_read, tx_busy, tx_done);
endinterface

// File: rtl/usb_tx_bit_timer.sv
// Bit-time counter; bit_strobe marks the last cycle of a bit, pre_strobe the one before.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    output logic bit_strobe,
    output logic pre_strobe
);
    localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)            cnt <= '0;
        else if (!en)          cnt <= '0;
        else if (cnt == LAST)  cnt <= '0;
        else                   cnt <= cnt + 1'b1;
    end

    assign bit_strobe = en && (cnt == LAST);
    assign pre_strobe = en && (cnt == PRE);
endmodule

// File: rtl/usb_tx.sv
// USB full-speed packet transmitter: SYNC, FIFO bytes, EOP; NRZI with bit stuffing.
module usb_tx
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic     clk,
    input  logic     n_rst,
    usb_tx_if.slave  bus,
    output logic     d_plus,
    output logic     d_minus
);
    tx_state_t   state, state_n;
    logic [7:0]  sh, sh_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [2:0]  ones, ones_n;
    logic        eop_cnt, eop_cnt_n;
    logic [1:0]  line, line_n;
    logic        rd, rd_n;
    logic        busy, busy_n;
    logic        done, done_n;
    logic        bit_strobe, pre_strobe;
    logic        stuff_due, byte_end;

    tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .en         (state != IDLE && state != DONE),
        .bit_strobe (bit_strobe),
        .pre_strobe (pre_strobe)
    );

    // ones already counts the bit on the line, so a stuff is owed once it hits the limit.
    assign stuff_due = (ones == 3'(STUFF_LIMIT));
    assign byte_end  = (bit_idx == 3'd7) && !stuff_due;

    always_comb begin
        state_n   = state;
        sh_n      = sh;
        bit_idx_n = bit_idx;
        ones_n    = ones;
        eop_cnt_n = eop_cnt;
        line_n    = line;
        busy_n    = busy;
        rd_n      = 1'b0;
        done_n    = 1'b0;
        case (state)
            IDLE: if (bus.tx_start) begin
                state_n   = SYNC;
                sh_n      = SYNC_BYTE;
                bit_idx_n = 3'd0;
                ones_n    = {2'b00, SYNC_BYTE[0]};
                line_n    = nrzi(LINE_J, SYNC_BYTE[0]);
                busy_n    = 1'b1;
            end
            SYNC, DATA: begin
                // Pop one cycle early so the byte is captured on the boundary edge.
                if (pre_strobe) rd_n = byte_end && !bus.tx_empty;
                if (bit_strobe) begin
                    if (stuff_due) begin
                        line_n = nrzi(line, 1'b0);
                        ones_n = 3'd0;
                    end else if (bit_idx != 3'd7) begin
                        sh_n      = {1'b0, sh[7:1]};
                        bit_idx_n = bit_idx + 3'd1;
                        line_n    = nrzi(line, sh[1]);
                        ones_n    = sh[1] ? ones + 3'd1 : 3'd0;
                    end else if (rd) begin
                        state_n   = DATA;
                        sh_n      = bus.tx_data;
                        bit_idx_n = 3'd0;
                        line_n    = nrzi(line, bus.tx_data[0]);
                        ones_n    = bus.tx_data[0] ? ones + 3'd1 : 3'd0;
                    end else begin
                        state_n   = EOP_SE0;
                        line_n    = LINE_SE0;
                        eop_cnt_n = 1'b0;
                    end
                end
            end
            EOP_SE0: if (bit_strobe) begin
                if (eop_cnt) begin
                    state_n = EOP_J;
                    line_n  = LINE_J;
                end else begin
                    eop_cnt_n = 1'b1;
                end
            end
            EOP_J: if (bit_strobe) begin
                state_n = DONE;
                done_n  = 1'b1;
                busy_n  = 1'b0;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            sh      <= '0;
            bit_idx <= '0;
            ones    <= '0;
            eop_cnt <= 1'b0;
            line    <= LINE_J;
            rd      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            sh      <= sh_n;
            bit_idx <= bit_idx_n;
            ones    <= ones_n;
            eop_cnt <= eop_cnt_n;
            line    <= line_n;
            rd      <= rd_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    assign d_plus      = line[1];
    assign d_minus     = line[0];
    assign bus.tx_read = rd;
    assign bus.tx_busy = busy;
    assign bus.tx_done = done;
endmodule
